// File: rtl/bin_mgr_pkg.sv
// bin_mgr_pkg: shared FSM states, default widths and CHECK routing for the bin manager.
package bin_mgr_pkg;
   localparam int WIDTH_BIN_ID_DEF = 10;
   localparam int WIDTH_CNT_DEF    = 16;
   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_STORE, S_WAIT_STORE, S_LOAD, S_WAIT_LOAD, S_GRANT} state_e;
   typedef enum logic [1:0] {ROUTE_HIT, ROUTE_STORE, ROUTE_LOAD} route_e;
   function automatic route_e route_f(input logic cur_valid, input logic same_bin, input logic dirty);
      return (cur_valid && same_bin) ? ROUTE_HIT : (cur_valid && dirty) ? ROUTE_STORE : ROUTE_LOAD;
   endfunction
endpackage

// File: rtl/bin_req_fifo.sv
// bin_req_fifo: synchronous FIFO of pending bin requests with registered full/empty flags.
module bin_req_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [AW:0]      r_count, w_count_nxt;
   logic             r_full, r_empty, w_push, w_pop;
   assign w_push      = push && !r_full;
   assign w_pop       = pop && !r_empty;
   assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
   assign dout        = r_mem[r_rd_ptr];
   assign full        = r_full;
   assign empty       = r_empty;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= w_count_nxt == FULL_CNT;
         r_empty <= w_count_nxt == '0;
      end
   end
endmodule

// File: rtl/bin_switch_ctrl.sv
// bin_switch_ctrl: queues SAT-engine bin requests and sequences store/load/grant per request.
// Optional watchdog on the wait states is built when BIN_SWITCH_TIMEOUT_EN is defined.
module bin_switch_ctrl import bin_mgr_pkg::*; #(
   parameter int WIDTH_BIN_ID = WIDTH_BIN_ID_DEF,
   parameter int FIFO_DEPTH   = 4,
   parameter int WIDTH_CNT    = WIDTH_CNT_DEF
`ifdef BIN_SWITCH_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid_i,
   input  logic [WIDTH_BIN_ID-1:0] req_bin_i,
   output logic                    req_ready_o,
   input  logic                    engine_dirty_i,
   output logic                    start_store_o,
   output logic [WIDTH_BIN_ID-1:0] store_bin_o,
   input  logic                    done_store_i,
   output logic                    start_load_o,
   output logic [WIDTH_BIN_ID-1:0] request_bin_num_o,
   input  logic                    done_load_i,
   output logic                    grant_valid_o,
   output logic [WIDTH_BIN_ID-1:0] grant_bin_o,
   output logic [WIDTH_BIN_ID-1:0] cur_bin_o,
   output logic                    cur_bin_valid_o,
   output logic                    busy_o,
   output logic [WIDTH_CNT-1:0]    load_cnt_o,
   output logic                    err_timeout_o
);
   state_e                  r_state;
   route_e                  w_route;
   logic [WIDTH_BIN_ID-1:0] r_req, r_cur_bin, r_store_bin, r_req_bin_num, r_grant_bin, w_head;
   logic                    r_cur_valid, r_start_store, r_start_load, r_grant_valid;
   logic [WIDTH_CNT-1:0]    r_load_cnt;
   logic                    w_full, w_empty, w_pop;
   assign w_pop   = (r_state == S_IDLE) && !w_empty;
   assign w_route = route_f(r_cur_valid, r_req == r_cur_bin, engine_dirty_i);
   bin_req_fifo #(.WIDTH(WIDTH_BIN_ID), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (req_valid_i),
      .pop   (w_pop),
      .din   (req_bin_i),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );
`ifdef BIN_SWITCH_TIMEOUT_EN
   localparam int W_TO = $clog2(TIMEOUT_CYCLES);
   localparam logic [W_TO-1:0] TO_LAST = W_TO'(TIMEOUT_CYCLES - 1);
   logic [W_TO-1:0] r_wait_cnt;
   logic            r_err, w_to_last;
   assign w_to_last     = r_wait_cnt == TO_LAST;
   assign err_timeout_o = r_err;
`else
   assign err_timeout_o = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_req         <= '0;
         r_cur_bin     <= '0;
         r_cur_valid   <= 1'b0;
         r_start_store <= 1'b0;
         r_store_bin   <= '0;
         r_start_load  <= 1'b0;
         r_req_bin_num <= '0;
         r_grant_valid <= 1'b0;
         r_grant_bin   <= '0;
         r_load_cnt    <= '0;
`ifdef BIN_SWITCH_TIMEOUT_EN
         r_wait_cnt    <= '0;
         r_err         <= 1'b0;
`endif
      end else begin
         r_start_store <= 1'b0;
         r_start_load  <= 1'b0;
         r_grant_valid <= 1'b0;
         case (r_state)
            S_IDLE: if (!w_empty) begin
               r_req   <= w_head;
               r_state <= S_CHECK;
            end
            S_CHECK: r_state <= (w_route == ROUTE_HIT) ? S_GRANT : (w_route == ROUTE_STORE) ? S_STORE : S_LOAD;
            S_STORE: begin
               r_start_store <= 1'b1;
               r_store_bin   <= r_cur_bin;
               r_state       <= S_WAIT_STORE;
`ifdef BIN_SWITCH_TIMEOUT_EN
               r_wait_cnt    <= '0;
`endif
            end
            // a done coinciding with the start pulse belongs to no transfer of ours
            S_WAIT_STORE: begin
               if (done_store_i && !r_start_store) begin
                  r_cur_valid <= 1'b0;
                  r_state     <= S_LOAD;
               end
`ifdef BIN_SWITCH_TIMEOUT_EN
               else if (w_to_last) begin
                  r_err       <= 1'b1;
                  r_cur_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end else r_wait_cnt <= r_wait_cnt + W_TO'(1);
`endif
            end
            S_LOAD: begin
               r_start_load  <= 1'b1;
               r_req_bin_num <= r_req;
               r_load_cnt    <= (&r_load_cnt) ? r_load_cnt : r_load_cnt + WIDTH_CNT'(1);
               r_state       <= S_WAIT_LOAD;
`ifdef BIN_SWITCH_TIMEOUT_EN
               r_wait_cnt    <= '0;
`endif
            end
            S_WAIT_LOAD: begin
               if (done_load_i && !r_start_load) r_state <= S_GRANT;
`ifdef BIN_SWITCH_TIMEOUT_EN
               else if (w_to_last) begin
                  r_err       <= 1'b1;
                  r_cur_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end else r_wait_cnt <= r_wait_cnt + W_TO'(1);
`endif
            end
            S_GRANT: begin
               r_grant_valid <= 1'b1;
               r_grant_bin   <= r_req;
               r_cur_bin     <= r_req;
               r_cur_valid   <= 1'b1;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign req_ready_o       = !w_full;
   assign start_store_o     = r_start_store;
   assign store_bin_o       = r_store_bin;
   assign start_load_o      = r_start_load;
   assign request_bin_num_o = r_req_bin_num;
   assign grant_valid_o     = r_grant_valid;
   assign grant_bin_o       = r_grant_bin;
   assign cur_bin_o         = r_cur_bin;
   assign cur_bin_valid_o   = r_cur_valid;
   assign busy_o            = (r_state != S_IDLE) || !w_empty;
   assign load_cnt_o        = r_load_cnt;
endmodule

// File: tb/tb_bin_switch_ctrl.sv
// tb_bin_switch_ctrl: directed self-checking bench for bin_switch_ctrl (timeout step built with BIN_SWITCH_TIMEOUT_EN).
module tb_bin_switch_ctrl;
   logic       clk = 1'b0;
   logic       rst, req_valid_i, req_ready_o, engine_dirty_i;
   logic [9:0] req_bin_i, store_bin_o, request_bin_num_o, grant_bin_o, cur_bin_o;
   logic       start_store_o, done_store_i, start_load_o, done_load_i, grant_valid_o;
   logic       cur_bin_valid_o, busy_o, err_timeout_o;
   logic [15:0] load_cnt_o;
   int n_pass = 0, n_total = 0;
   int n_store = 0, n_load = 0, n_grant = 0;
   int g0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (start_store_o) n_store <= n_store + 1;
      if (start_load_o) n_load <= n_load + 1;
      if (grant_valid_o) n_grant <= n_grant + 1;
   end
   bin_switch_ctrl #(.WIDTH_BIN_ID(10), .FIFO_DEPTH(4), .WIDTH_CNT(16)
`ifdef BIN_SWITCH_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid_i       (req_valid_i),
      .req_bin_i         (req_bin_i),
      .req_ready_o       (req_ready_o),
      .engine_dirty_i    (engine_dirty_i),
      .start_store_o     (start_store_o),
      .store_bin_o       (store_bin_o),
      .done_store_i      (done_store_i),
      .start_load_o      (start_load_o),
      .request_bin_num_o (request_bin_num_o),
      .done_load_i       (done_load_i),
      .grant_valid_o     (grant_valid_o),
      .grant_bin_o       (grant_bin_o),
      .cur_bin_o         (cur_bin_o),
      .cur_bin_valid_o   (cur_bin_valid_o),
      .busy_o            (busy_o),
      .load_cnt_o        (load_cnt_o),
      .err_timeout_o     (err_timeout_o)
   );
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic push(input logic [9:0] b);
      req_valid_i = 1'b1;
      req_bin_i   = b;
      tick();
      req_valid_i = 1'b0;
   endtask
   task automatic wait_ev(input int which, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         seen = (which == 0) ? start_store_o : (which == 1) ? start_load_o : grant_valid_o;
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
   endtask
   task automatic serve_load(input logic [9:0] b);
      wait_ev(1, "start_load");
      chk("load_bin", 32'(request_bin_num_o), 32'(b));
      tick();
      done_load_i = 1'b1;
      tick();
      done_load_i = 1'b0;
      wait_ev(2, "grant");
      chk("grant_bin", 32'(grant_bin_o), 32'(b));
   endtask
   initial begin
      rst = 1'b1; req_valid_i = 1'b0; req_bin_i = '0; engine_dirty_i = 1'b0;
      done_store_i = 1'b0; done_load_i = 1'b0;
      repeat (3) tick();
      chk("rst_ready", 32'(req_ready_o), 32'd1);
      chk("rst_start_store", 32'(start_store_o), 32'd0);
      chk("rst_start_load", 32'(start_load_o), 32'd0);
      chk("rst_grant", 32'(grant_valid_o), 32'd0);
      chk("rst_cur_valid", 32'(cur_bin_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_load_cnt", 32'(load_cnt_o), 32'd0);
      chk("rst_err", 32'(err_timeout_o), 32'd0);
      rst = 1'b0;
      tick();
      // cold request: load only
      push(10'd5);
      serve_load(10'd5);
      chk("cold_no_store", 32'(n_store), 32'd0);
      chk("cold_cur_bin", 32'(cur_bin_o), 32'd5);
      chk("cold_cur_valid", 32'(cur_bin_valid_o), 32'd1);
      chk("cold_load_cnt", 32'(load_cnt_o), 32'd1);
      // hit: grant 3 cycles after the push edge, stray dones ignored
      done_load_i = 1'b1; done_store_i = 1'b1;
      push(10'd5);
      tick(); tick();
      chk("hit_grant_early", 32'(grant_valid_o), 32'd0);
      tick();
      chk("hit_grant", 32'(grant_valid_o), 32'd1);
      chk("hit_grant_bin", 32'(grant_bin_o), 32'd5);
      done_load_i = 1'b0; done_store_i = 1'b0;
      tick();
      chk("hit_no_load", 32'(n_load), 32'd1);
      chk("hit_no_store", 32'(n_store), 32'd0);
      chk("hit_load_cnt", 32'(load_cnt_o), 32'd1);
      // dirty miss: store 5 then load 9
      engine_dirty_i = 1'b1;
      push(10'd9);
      wait_ev(0, "start_store");
      chk("store_bin", 32'(store_bin_o), 32'd5);
      done_store_i = 1'b1;
      tick();
      done_store_i = 1'b0;
      engine_dirty_i = 1'b0;
      repeat (4) tick();
      chk("store_done_same_cycle_ignored", 32'(n_load), 32'd1);
      chk("store_bin_held", 32'(store_bin_o), 32'd5);
      done_store_i = 1'b1;
      tick();
      done_store_i = 1'b0;
      wait_ev(1, "start_load_9");
      chk("miss_cur_valid_cleared", 32'(cur_bin_valid_o), 32'd0);
      chk("miss_load_bin", 32'(request_bin_num_o), 32'd9);
      tick();
      done_load_i = 1'b1;
      tick();
      done_load_i = 1'b0;
      wait_ev(2, "grant_9");
      chk("miss_grant_bin", 32'(grant_bin_o), 32'd9);
      chk("miss_cur_bin", 32'(cur_bin_o), 32'd9);
      chk("miss_load_cnt", 32'(load_cnt_o), 32'd2);
      chk("miss_one_store", 32'(n_store), 32'd1);
      // fill the queue while the FSM waits on a load
      push(10'd7);
      wait_ev(1, "start_load_7");
      req_valid_i = 1'b1;
      req_bin_i = 10'd1; tick();
      req_bin_i = 10'd2; tick();
      req_bin_i = 10'd3; tick();
      chk("ready_after_3", 32'(req_ready_o), 32'd1);
      req_bin_i = 10'd4; tick();
      chk("ready_after_4", 32'(req_ready_o), 32'd0);
      req_bin_i = 10'd6; tick();
      req_valid_i = 1'b0;
      chk("full_busy", 32'(busy_o), 32'd1);
      tick();
      done_load_i = 1'b1;
      tick();
      done_load_i = 1'b0;
      wait_ev(2, "grant_7");
      chk("grant_7_bin", 32'(grant_bin_o), 32'd7);
      for (int b = 1; b <= 4; b++) serve_load(10'(b));
      repeat (10) tick();
      chk("dropped_no_load", 32'(n_load), 32'd7);
      chk("fill_load_cnt", 32'(load_cnt_o), 32'd7);
      chk("fill_idle_busy", 32'(busy_o), 32'd0);
      // reset in WAIT_LOAD, then a stale done
      push(10'd8);
      wait_ev(1, "start_load_8");
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
      chk("mid_rst_start_load", 32'(start_load_o), 32'd0);
      chk("mid_rst_req_bin", 32'(request_bin_num_o), 32'd0);
      chk("mid_rst_cur_bin", 32'(cur_bin_o), 32'd0);
      chk("mid_rst_cur_valid", 32'(cur_bin_valid_o), 32'd0);
      chk("mid_rst_load_cnt", 32'(load_cnt_o), 32'd0);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      rst = 1'b0;
      g0 = n_grant;
      done_load_i = 1'b1;
      tick(); tick();
      done_load_i = 1'b0;
      tick();
      chk("stale_done_no_grant", 32'(n_grant - g0), 32'd0);
      chk("stale_done_idle", 32'(busy_o), 32'd0);
`ifdef BIN_SWITCH_TIMEOUT_EN
      push(10'd3);
      wait_ev(1, "start_load_3");
      repeat (15) tick();
      chk("to_err_early", 32'(err_timeout_o), 32'd0);
      tick();
      chk("to_err", 32'(err_timeout_o), 32'd1);
      chk("to_idle", 32'(busy_o), 32'd0);
      chk("to_cur_valid", 32'(cur_bin_valid_o), 32'd0);
      repeat (3) tick();
      chk("to_sticky", 32'(err_timeout_o), 32'd1);
`else
      chk("no_timeout_err", 32'(err_timeout_o), 32'd0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
